uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 40 ++++
 rtl/uart_arb_out_reg.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state type and round-robin pick helper for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int MAX_REQ   = 8;
  localparam int MAX_GID_W = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_GID_W-1:0] idx;
  } rr_pick_t;

  function automatic int gid_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // First set bit of valid_vec at or after ptr, wrapping at num_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid_vec,
                                       input logic [MAX_GID_W-1:0] ptr,
                                       input int                   num_req);
    rr_pick_t res;
    int       idx;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % num_req;
      if (k < num_req && !res.found && valid_vec[idx[MAX_GID_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[MAX_GID_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_arb_out_reg.sv
// rtl/uart_arb_out_reg.sv - single-entry valid/ready holding register feeding the UART core
module uart_arb_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter sharing one UART transmit stream
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  NUM_REQ       = 2,
  parameter int  DATA_W        = 8,
  parameter int  STALL_TIMEOUT = 1024,
  localparam int GID_W         = gid_width(NUM_REQ)
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [GID_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      abort_pulse
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]   next_ptr;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;
  logic               own_valid, own_last, accept, oreg_ready;
  logic [DATA_W-1:0]  own_data;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
  end

  assign pick      = rr_pick(valid_ext, MAX_GID_W'(rr_ptr_q), NUM_REQ);
  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign own_data  = req_data[grant_q*DATA_W +: DATA_W];
  assign next_ptr  = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    stall_d     = stall_q;
    req_ready   = '0;
    accept      = 1'b0;
    abort_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (pick.found) begin
          grant_d = GID_W'(pick.idx);
          busy_d  = 1'b1;
          state_d = OWN;
        end
      end
      OWN: begin
        req_ready[grant_q] = oreg_ready;
        accept             = own_valid && oreg_ready;
        stall_d            = own_valid ? '0 : stall_q + 1'b1;
        if (accept && own_last) begin
          rr_ptr_d = next_ptr;
          busy_d   = 1'b0;
          state_d  = DRAIN;
        end else if (!own_valid && stall_q == CNT_W'(STALL_TIMEOUT - 1)) begin
          // A byte already latched still goes out; DRAIN waits for it.
          abort_pulse = 1'b1;
          rr_ptr_d    = next_ptr;
          busy_d      = 1'b0;
          stall_d     = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (!tx_valid || tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      stall_q  <= stall_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

  uart_arb_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .in_valid_i  (accept),
    .in_data_i   (own_data),
    .in_ready_o  (oreg_ready),
    .out_valid_o (tx_valid),
    .out_data_o  (tx_data),
    .out_ready_i (tx_ready)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            tx_valid, tx_ready, busy, abort_pulse;
  logic [DW-1:0]   tx_data;
  logic [1:0]      grant_id;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .DATA_W        (DW),
    .STALL_TIMEOUT (TO)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .abort_pulse   (abort_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;
  typedef struct packed { logic [1:0] id; logic [7:0] data; logic [31:0] cyc; } obs_t;
  typedef struct packed { logic [3:0] mask; logic [2:0] n; logic [7:0] order; } vec_t;
  typedef logic [8:0] byte_q_t[$];

  exp_t    exp_q[$];
  obs_t    obs_q[$];
  int      abort_q[$];
  int      match_cyc[$];
  byte_q_t rq[N];
  logic [N-1:0] fire = '0;
  logic    tx_ready_v;
  int      obs_rd = 0;
  int      checks = 0;
  int      errors = 0;

  // Monitor: handshakes seen here complete at the following rising edge.
  always @(negedge clk) begin
    fire = req_valid & req_ready;
    if (tx_valid && tx_ready) obs_q.push_back('{id: grant_id, data: tx_data, cyc: cyc});
    if (abort_pulse) abort_q.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    logic [8:0] head;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      head                 = (rq[i].size() > 0) ? rq[i][0] : 9'h0;
      req_valid[i]         = (rq[i].size() > 0);
      req_last[i]          = head[8];
      req_data[i*DW +: DW] = head[7:0];
    end
    tx_ready = tx_ready_v;
  endtask

  task automatic load(input int id, input logic [7:0] data, input logic last);
    rq[id].push_back({last, data});
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
    exp_q.push_back('{id: id, data: data});
  endtask

  function automatic bit rq_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic sb_compare();
    obs_t o;
    exp_t e;
    while (obs_rd < obs_q.size()) begin
      o = obs_q[obs_rd];
      obs_rd++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0d:%02h required=none", o.id, o.data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_id_byte", {o.id, o.data}, {e.id, e.data});
        match_cyc.push_back(int'(o.cyc));
      end
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      sb_compare();
      done = (exp_q.size() == 0) && !busy && !tx_valid && rq_empty();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", name, exp_q.size());
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] m, input int n,
                               input logic [1:0] o0, input logic [1:0] o1,
                               input logic [1:0] o2, input logic [1:0] o3);
    vec_t r;
    r.mask  = m;
    r.n     = 3'(n);
    r.order = {o3, o2, o1, o0};
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[9];
    logic [1:0] oid;
    int         t0, mbase, abase, t_last;

    // Grant order is derived by hand from the pointer left by the previous row.
    vecs[0] = mkv(4'b0011, 2, 0, 1, 0, 0);
    vecs[1] = mkv(4'b1111, 4, 2, 3, 0, 1);
    vecs[2] = mkv(4'b0101, 2, 2, 0, 0, 0);
    vecs[3] = mkv(4'b0011, 2, 1, 0, 0, 0);
    vecs[4] = mkv(4'b1001, 2, 3, 0, 0, 0);
    vecs[5] = mkv(4'b0100, 1, 2, 0, 0, 0);
    vecs[6] = mkv(4'b0101, 2, 0, 2, 0, 0);
    vecs[7] = mkv(4'b1000, 1, 3, 0, 0, 0);
    vecs[8] = mkv(4'b0011, 2, 0, 1, 0, 0);

    rst_n = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    tx_ready = 1'b0; tx_ready_v = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_abort", abort_pulse, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Single packet, tx_ready always high
    mbase = match_cyc.size();
    load(0, 8'h41, 0); load(0, 8'h42, 0); load(0, 8'h43, 1);
    push_exp(0, 8'h41); push_exp(0, 8'h42); push_exp(0, 8'h43);
    step();
    t0 = cyc;
    step(); step(); step();
    chk("t1_busy_last_accept", busy, 1);
    step();
    chk("t1_busy_after_last", busy, 0);
    drain(50, "t1");
    chk("t1_count", match_cyc.size() - mbase, 3);
    for (int k = 0; k < 3; k++)
      if (match_cyc.size() > mbase + k) chk("t1_tx_cycle", match_cyc[mbase+k], t0 + 2 + k);

    // Return pointer to 0, then two competing 2-byte packets
    load(3, 8'h30, 1); push_exp(3, 8'h30);
    drain(50, "ptr0");
    load(0, 8'hA0, 0); load(0, 8'hA1, 1);
    load(1, 8'hB0, 0); load(1, 8'hB1, 1);
    push_exp(0, 8'hA0); push_exp(0, 8'hA1); push_exp(1, 8'hB0); push_exp(1, 8'hB1);
    drain(80, "contend");

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < N; i++)
        if (vecs[v].mask[i]) load(i, {v[3:0], 4'(i)}, 1);
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        oid = vecs[v].order[2*k +: 2];
        push_exp(oid, {v[3:0], 2'b00, oid});
      end
      drain(100, "vec");
    end

    // Backpressure: tx_ready low for 5 cycles while C1 sits in the register
    load(2, 8'hC0, 0); load(2, 8'hC1, 0); load(2, 8'hC2, 0); load(2, 8'hC3, 1);
    push_exp(2, 8'hC0); push_exp(2, 8'hC1); push_exp(2, 8'hC2); push_exp(2, 8'hC3);
    step(); step(); step();
    tx_ready_v = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_tx_valid", tx_valid, 1);
      chk("bp_tx_data", tx_data, 8'hC1);
      chk("bp_req_ready", req_ready, 0);
      if (i == 4) tx_ready_v = 1'b1;
      step();
    end
    drain(50, "bp");
    chk("no_abort_yet", abort_q.size(), 0);

    // Stall timeout on requester 1, requester 0 waiting behind it
    abase = abort_q.size();
    load(1, 8'hD0, 0); push_exp(1, 8'hD0);
    step();
    step();
    t_last = cyc;
    step();
    load(0, 8'hE0, 1); push_exp(0, 8'hE0);
    drain(100, "timeout");
    chk("to_abort_count", abort_q.size() - abase, 1);
    if (abort_q.size() > abase) chk("to_abort_cycle", abort_q[abase], t_last + TO);

    // Reset during byte 2 of 4
    load(1, 8'hF0, 0); load(1, 8'hF1, 0); load(1, 8'hF2, 0); load(1, 8'hF3, 1);
    push_exp(1, 8'hF0);
    step(); step(); step(); step();
    sb_compare();
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_grant", grant_id, 1);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    req_valid = '0; req_last = '0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_grant_id", grant_id, 0);
    chk("mid_rst_sb_empty", exp_q.size(), 0);
    step(); step();
    rst_n = 1'b1;
    load(0, 8'h71, 0); load(0, 8'h72, 1);
    push_exp(0, 8'h71); push_exp(0, 8'h72);
    drain(50, "post_rst");
    sb_compare();
    chk("final_abort_total", abort_q.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
